// File: rtl/rx_unstuff_deser_if.sv
// rx_unstuff_deser_if: bus between the upstream NRZI decoder/EOP detector and the unstuffing deserializer
// Fields: bit_strobe/d_orig qualify each decoded bit, decode_err flags a line error, end_packet marks EOP;
// rx_data/byte_valid carry assembled bytes, pkt_start/pkt_done/pkt_err frame packets, rx_active shows busy.
// Modports: master drives the decoder side (inputs of the deserializer), slave is the deserializer.
interface rx_unstuff_deser_if;
  logic       bit_strobe;
  logic       d_orig;
  logic       decode_err;
  logic       end_packet;
  logic [7:0] rx_data;
  logic       byte_valid;
  logic       pkt_start;
  logic       pkt_done;
  logic       pkt_err;
  logic       rx_active;
  modport master (
    output bit_strobe, d_orig, decode_err, end_packet,
    input  rx_data, byte_valid, pkt_start, pkt_done, pkt_err, rx_active
  );
  modport slave (
    input  bit_strobe, d_orig, decode_err, end_packet,
    output rx_data, byte_valid, pkt_start, pkt_done, pkt_err, rx_active
  );
endinterface

// File: rtl/rx_unstuff_deser.sv
// rx_unstuff_deser: SYNC detection, bit unstuffing and LSB-first byte assembly for a USB-style receiver
// Ports: clk, rst (async active-high), bus (rx_unstuff_deser_if.slave) carrying strobed bits, line error,
// EOP in and rx_data/byte_valid/pkt_start/pkt_done/pkt_err/rx_active out (all registered).
// Option: define RX_STUFF_ERR_EN to treat a 1 in a stuffed-bit position as a packet error.
module rx_unstuff_deser (
  input logic clk,
  input logic rst,
  rx_unstuff_deser_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SYNC, DATA, ERR} state_t;
  state_t state;
  logic [7:0] sr;
  logic [2:0] bcnt;
  logic [2:0] ones;
  logic [7:0] shifted;
  logic stuffed;
  logic stuff_err;
  assign shifted = {bus.d_orig, sr[7:1]};
  // a bit following six consecutive ones is a stuffed bit
  assign stuffed = ones == 3'd6;
`ifdef RX_STUFF_ERR_EN
  assign stuff_err = stuffed & bus.d_orig;
`else
  assign stuff_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sr <= 8'h00;
      bcnt <= 3'd0;
      ones <= 3'd0;
      bus.rx_data <= 8'h00;
      bus.byte_valid <= 1'b0;
      bus.pkt_start <= 1'b0;
      bus.pkt_done <= 1'b0;
      bus.pkt_err <= 1'b0;
      bus.rx_active <= 1'b0;
    end else begin
      bus.byte_valid <= 1'b0;
      bus.pkt_start <= 1'b0;
      bus.pkt_done <= 1'b0;
      bus.pkt_err <= 1'b0;
      if (bus.end_packet && state != IDLE) begin
        // EOP wins over everything; only a byte-aligned DATA packet ends cleanly
        state <= IDLE;
        bcnt <= 3'd0;
        ones <= 3'd0;
        bus.rx_active <= 1'b0;
        bus.pkt_done <= 1'b1;
        bus.pkt_err <= state != DATA || bcnt != 3'd0;
      end else if (bus.decode_err && (state == SYNC || state == DATA)) begin
        state <= ERR;
      end else if (bus.bit_strobe) begin
        case (state)
          IDLE: if (!bus.d_orig) begin
            state <= SYNC;
            sr <= shifted;
            bcnt <= 3'd1;
            bus.rx_active <= 1'b1;
          end
          SYNC: begin
            sr <= shifted;
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              state <= shifted == 8'h80 ? DATA : ERR;
              bus.pkt_start <= shifted == 8'h80;
              // the final SYNC 1 starts the ones run for stuffing
              ones <= 3'd1;
            end
          end
          DATA: begin
            if (stuff_err)
              state <= ERR;
            else if (stuffed)
              ones <= 3'd0;
            else begin
              ones <= bus.d_orig ? ones + 3'd1 : 3'd0;
              sr <= shifted;
              bcnt <= bcnt + 3'd1;
              if (bcnt == 3'd7) begin
                bus.rx_data <= shifted;
                bus.byte_valid <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_unstuff_deser.sv
// tb_rx_unstuff_deser: table-driven packet vectors plus hand sequences for reset, idle EOP and async abort
module tb_rx_unstuff_deser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  rx_unstuff_deser_if bus ();
  rx_unstuff_deser dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    string name;
    logic [31:0] bits;
    int n;
    int derr_at;
    bit eop_last;
    bit derr_eop;
    int e_start;
    int e_nb;
    logic [7:0] e_first;
    logic [7:0] e_last;
    bit e_err;
  } vec_t;

  vec_t vt[12];
  int nerr = 0;
  int nchk = 0;
  int nstart = 0;
  int nbv = 0;
  int ndone = 0;
  logic last_err = 1'b0;
  logic [7:0] blog[256];

  always @(negedge clk) begin
    if (bus.byte_valid) begin
      blog[nbv % 256] <= bus.rx_data;
      nbv <= nbv + 1;
    end
    if (bus.pkt_start) nstart <= nstart + 1;
    if (bus.pkt_done) begin
      ndone <= ndone + 1;
      last_err <= bus.pkt_err;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.bit_strobe = 1'b1;
    bus.d_orig = b;
    @(negedge clk);
    bus.bit_strobe = 1'b0;
    bus.d_orig = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int s0, b0, d0, nsend;
    #1;
    s0 = nstart;
    b0 = nbv;
    d0 = ndone;
    nsend = v.eop_last ? v.n - 1 : v.n;
    for (int i = 0; i < nsend; i++) begin
      if (i == v.derr_at) begin
        @(negedge clk);
        bus.decode_err = 1'b1;
        @(negedge clk);
        bus.decode_err = 1'b0;
      end
      send_bit(v.bits[i]);
    end
    @(negedge clk);
    chk({v.name, "_active"}, int'(bus.rx_active), 1);
    bus.end_packet = 1'b1;
    if (v.eop_last) begin
      bus.bit_strobe = 1'b1;
      bus.d_orig = v.bits[v.n - 1];
    end
    if (v.derr_eop) bus.decode_err = 1'b1;
    @(negedge clk);
    bus.end_packet = 1'b0;
    bus.bit_strobe = 1'b0;
    bus.d_orig = 1'b0;
    bus.decode_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk({v.name, "_done"}, ndone - d0, 1);
    chk({v.name, "_err"}, int'(last_err), int'(v.e_err));
    chk({v.name, "_start"}, nstart - s0, v.e_start);
    chk({v.name, "_bytes"}, nbv - b0, v.e_nb);
    if (nbv - b0 == v.e_nb && v.e_nb > 0) begin
      chk({v.name, "_first"}, int'(blog[b0 % 256]), int'(v.e_first));
      chk({v.name, "_last"}, int'(blog[(nbv - 1) % 256]), int'(v.e_last));
    end
    chk({v.name, "_idle"}, int'(bus.rx_active), 0);
  endtask

  initial begin
    int d0;
    vt[0]  = '{"a5",      32'h0000A580, 16, -1, 1'b0, 1'b0, 1, 1, 8'hA5, 8'hA5, 1'b0};
    vt[1]  = '{"stuff0",  32'h0001DF80, 17, -1, 1'b0, 1'b0, 1, 1, 8'hFF, 8'hFF, 1'b0};
`ifdef RX_STUFF_ERR_EN
    vt[2]  = '{"seven1s", 32'h0001FF80, 17, -1, 1'b0, 1'b0, 1, 0, 8'h00, 8'h00, 1'b1};
`else
    vt[2]  = '{"seven1s", 32'h0001FF80, 17, -1, 1'b0, 1'b0, 1, 1, 8'hFF, 8'hFF, 1'b0};
`endif
    vt[3]  = '{"badsync", 32'h000000C0,  8, -1, 1'b0, 1'b0, 0, 0, 8'h00, 8'h00, 1'b1};
    vt[4]  = '{"short",   32'h00000580, 11, -1, 1'b0, 1'b0, 1, 0, 8'h00, 8'h00, 1'b1};
    vt[5]  = '{"twobyte", 32'h00123C80, 24, -1, 1'b0, 1'b0, 1, 2, 8'h3C, 8'h12, 1'b0};
    vt[6]  = '{"derr",    32'h0007FD80, 19, 11, 1'b0, 1'b0, 1, 0, 8'h00, 8'h00, 1'b1};
    vt[7]  = '{"idle1s",  32'h00029603, 18, -1, 1'b0, 1'b0, 1, 1, 8'hA5, 8'hA5, 1'b0};
    vt[8]  = '{"stuff7e", 32'h00007E80, 17, -1, 1'b0, 1'b0, 1, 1, 8'h7E, 8'h7E, 1'b0};
    vt[9]  = '{"span",    32'h0007E080, 25, -1, 1'b0, 1'b0, 1, 2, 8'hE0, 8'h07, 1'b0};
    vt[10] = '{"eopbit",  32'h0000A580, 16, -1, 1'b1, 1'b0, 1, 0, 8'h00, 8'h00, 1'b1};
    vt[11] = '{"eopderr", 32'h0000A580, 16, -1, 1'b0, 1'b1, 1, 1, 8'hA5, 8'hA5, 1'b0};
    bus.bit_strobe = 1'b0;
    bus.d_orig = 1'b0;
    bus.decode_err = 1'b0;
    bus.end_packet = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rx_data", int'(bus.rx_data), 0);
    chk("rst_byte_valid", int'(bus.byte_valid), 0);
    chk("rst_pkt_start", int'(bus.pkt_start), 0);
    chk("rst_pkt_done", int'(bus.pkt_done), 0);
    chk("rst_pkt_err", int'(bus.pkt_err), 0);
    chk("rst_rx_active", int'(bus.rx_active), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    d0 = ndone;
    bus.end_packet = 1'b1;
    bus.decode_err = 1'b1;
    @(negedge clk);
    bus.end_packet = 1'b0;
    bus.decode_err = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_eop_done", ndone - d0, 0);
    chk("idle_eop_active", int'(bus.rx_active), 0);
    for (int i = 0; i < 12; i++) run_vec(vt[i]);
    #1;
    d0 = ndone;
    for (int i = 0; i < 11; i++) send_bit(vt[4].bits[i]);
    @(negedge clk);
    chk("abort_active_before", int'(bus.rx_active), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_active", int'(bus.rx_active), 0);
    chk("abort_rx_data", int'(bus.rx_data), 0);
    chk("abort_pkt_done", int'(bus.pkt_done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("abort_no_done", ndone - d0, 0);
    run_vec(vt[0]);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
